// File: rtl/rtc_core_multi.sv
// ----------------------------------------------------------------------------
// rtc_core_multi : prescaled counter with ALRM_NUM one-shot/periodic alarms.
// Optional capture register built only when RTC_CAPTURE_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rtc_core_multi #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSC_WIDTH  = 16,
  parameter int ALRM_NUM   = 4,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  sel_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  input  logic                  cap_i,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] c_adr_ctrl = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_adr_pscr = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_adr_cnt  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] c_adr_stat = ADDR_WIDTH'(3);

  logic                 r_en, r_ovie, r_tie;
  logic [PSC_WIDTH-1:0] r_pscr, r_div;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovif, r_tif;

  logic                 w_wr, w_wr_ctrl, w_wr_pscr, w_wr_cnt, w_wr_stat;
  logic                 w_tick, w_tick_eff, w_ovf;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [ALRM_NUM-1:0]  w_aif, w_aen, w_aie, w_per;
  logic [CNT_WIDTH-1:0] w_aval [ALRM_NUM];
  logic [CNT_WIDTH-1:0] w_aprd [ALRM_NUM];
  logic [31:0]          w_rdata;
  logic                 w_hit;

  assign w_wr      = sel_i & we_i;
  assign w_wr_ctrl = w_wr & (addr_i == c_adr_ctrl);
  assign w_wr_pscr = w_wr & (addr_i == c_adr_pscr);
  assign w_wr_cnt  = w_wr & (addr_i == c_adr_cnt);
  assign w_wr_stat = w_wr & (addr_i == c_adr_stat);

  // A software CNT write swallows a coincident tick entirely.
  assign w_tick     = r_en & (r_div == r_pscr);
  assign w_tick_eff = w_tick & ~w_wr_cnt;
  assign w_cnt_inc  = r_cnt + CNT_WIDTH'(1);
  assign w_ovf      = w_tick_eff & (&r_cnt);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_en   <= 1'b0;
      r_ovie <= 1'b0;
      r_tie  <= 1'b0;
      r_pscr <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_ovif <= 1'b0;
      r_tif  <= 1'b0;
    end else begin
      if (w_wr_ctrl) {r_tie, r_ovie, r_en} <= wdata_i[2:0];
      if (w_wr_pscr) r_pscr <= wdata_i[PSC_WIDTH-1:0];
      if (w_wr_pscr)  r_div <= '0;
      else if (r_en)  r_div <= w_tick ? '0 : r_div + PSC_WIDTH'(1);
      if (w_wr_cnt)        r_cnt <= wdata_i[CNT_WIDTH-1:0];
      else if (w_tick_eff) r_cnt <= w_cnt_inc;
      r_ovif <= (r_ovif & ~(w_wr_stat & wdata_i[0])) | w_ovf;
      r_tif  <= (r_tif  & ~(w_wr_stat & wdata_i[1])) | w_tick_eff;
    end
  end

  for (genvar i = 0; i < ALRM_NUM; i++) begin : g_alarm
    localparam logic [ADDR_WIDTH-1:0] c_adr_val = ADDR_WIDTH'(4 + 3*i);
    localparam logic [ADDR_WIDTH-1:0] c_adr_cfg = ADDR_WIDTH'(5 + 3*i);
    localparam logic [ADDR_WIDTH-1:0] c_adr_prd = ADDR_WIDTH'(6 + 3*i);

    logic [CNT_WIDTH-1:0] r_aval, r_aprd;
    logic                 r_aen, r_aie, r_per, r_aif;
    logic                 w_fire;

    // Match against the post-increment value so a freshly written CNT never fires.
    assign w_fire = w_tick_eff & r_aen & (w_cnt_inc == r_aval);

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        r_aval <= '0;
        r_aprd <= '0;
        r_aen  <= 1'b0;
        r_aie  <= 1'b0;
        r_per  <= 1'b0;
        r_aif  <= 1'b0;
      end else begin
        r_aif <= (r_aif & ~(w_wr_stat & wdata_i[2+i])) | w_fire;
        if (w_wr & (addr_i == c_adr_val)) r_aval <= wdata_i[CNT_WIDTH-1:0];
        else if (w_fire & r_per)          r_aval <= r_aval + r_aprd;
        if (w_wr & (addr_i == c_adr_cfg)) {r_per, r_aie, r_aen} <= wdata_i[2:0];
        else if (w_fire & ~r_per)         r_aen <= 1'b0;
        if (w_wr & (addr_i == c_adr_prd)) r_aprd <= wdata_i[CNT_WIDTH-1:0];
      end
    end

    assign w_aif[i]  = r_aif;
    assign w_aen[i]  = r_aen;
    assign w_aie[i]  = r_aie;
    assign w_per[i]  = r_per;
    assign w_aval[i] = r_aval;
    assign w_aprd[i] = r_aprd;
  end

`ifdef RTC_CAPTURE_EN
  localparam logic [ADDR_WIDTH-1:0] c_adr_cap = ADDR_WIDTH'(4 + 3*ALRM_NUM);
  logic [CNT_WIDTH-1:0] r_cap;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)   r_cap <= '0;
    else if (cap_i) r_cap <= r_cnt;
  end
`else
  logic w_unused_cap;
  assign w_unused_cap = cap_i;
`endif

  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b0;
    if (addr_i == c_adr_ctrl) begin
      w_hit = 1'b1; w_rdata = {29'b0, r_tie, r_ovie, r_en};
    end
    if (addr_i == c_adr_pscr) begin
      w_hit = 1'b1; w_rdata = 32'(r_pscr);
    end
    if (addr_i == c_adr_cnt) begin
      w_hit = 1'b1; w_rdata = 32'(r_cnt);
    end
    if (addr_i == c_adr_stat) begin
      w_hit = 1'b1; w_rdata = 32'({w_aif, r_tif, r_ovif});
    end
    for (int i = 0; i < ALRM_NUM; i++) begin
      if (addr_i == ADDR_WIDTH'(4 + 3*i)) begin
        w_hit = 1'b1; w_rdata = 32'(w_aval[i]);
      end
      if (addr_i == ADDR_WIDTH'(5 + 3*i)) begin
        w_hit = 1'b1; w_rdata = {29'b0, w_per[i], w_aie[i], w_aen[i]};
      end
      if (addr_i == ADDR_WIDTH'(6 + 3*i)) begin
        w_hit = 1'b1; w_rdata = 32'(w_aprd[i]);
      end
    end
`ifdef RTC_CAPTURE_EN
    if (addr_i == c_adr_cap) begin
      w_hit = 1'b1; w_rdata = 32'(r_cap);
    end
`endif
  end

  assign rdata_o = sel_i ? w_rdata : '0;
  assign err_o   = sel_i & ~w_hit;
  assign irq_o   = (r_ovif & r_ovie) | (r_tif & r_tie) | (|(w_aif & w_aie));

endmodule

`default_nettype wire
